// File: rtl/nic_axis_pkg.sv
// Shared types and constants for the NIC AXI-Stream TX path.
package nic_axis_pkg;

    localparam int unsigned PKT_CNT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_pkt_arb_if.sv
// AXI-Stream bundle carrying N parallel lanes; N=1 for the shared sink side.
interface axis_pkt_arb_if #(
    parameter int unsigned N     = 1,
    parameter int unsigned DATAW = 64
);
    localparam int unsigned KEEPW = DATAW / 8;

    logic [N*DATAW-1:0] tdata;
    logic [N*KEEPW-1:0] tkeep;
    logic [N-1:0]       tlast;
    logic [N-1:0]       tvalid;
    logic [N-1:0]       tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_pkt_arb_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from last_i+1, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [IDXW-1:0] winner_o,
    output logic            any_o
);

    logic [31:0] idx;
    logic        found;

    // Scan the NREQ positions after last_i in rotated order; the first hit wins.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(last_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx[IDXW-1:0]]) begin
                found    = 1'b1;
                winner_o = idx[IDXW-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/axis_pkt_arb.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink between NREQ masters.
// A grant is held from the first beat through the tlast handshake, so packets never interleave.
module axis_pkt_arb
    import nic_axis_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DATAW = 64
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    axis_pkt_arb_if.slave        s_axis,
    axis_pkt_arb_if.master       m_axis,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);

    localparam int unsigned KEEPW = DATAW / 8;
    localparam int unsigned IDXW  = $clog2(NREQ);

    arb_state_e           state_q;
    logic [IDXW-1:0]      g_q;
    logic [IDXW-1:0]      lp_q;
    logic [PKT_CNT_W-1:0] pkt_cnt_q;
    logic [NREQ-1:0]      grant_q;
    logic                 busy_q;

    logic [IDXW-1:0]      pick_idx;
    logic                 pick_any;
    logic                 pkt_done;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i    (s_axis.tvalid),
        .last_i   (lp_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    // Steer the owner's beat to the sink and the sink's ready back to the owner only.
    // m_axis.tvalid depends on g_q and the owner's tvalid, never on m_axis.tready.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = '0;
        m_axis.tvalid = '0;
        s_axis.tready = '0;
        if (state_q == BUSY) begin
            m_axis.tdata     = s_axis.tdata[32'(g_q)*DATAW +: DATAW];
            m_axis.tkeep     = s_axis.tkeep[32'(g_q)*KEEPW +: KEEPW];
            m_axis.tlast[0]  = s_axis.tlast[g_q];
            m_axis.tvalid[0] = s_axis.tvalid[g_q];
            s_axis.tready[g_q] = m_axis.tready[0];
        end
    end

    assign pkt_done = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];

    // Arbitration FSM: pick in IDLE, hold the grant until the tlast handshake.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q   <= IDLE;
            g_q       <= '0;
            lp_q      <= IDXW'(NREQ - 1);  // requester 0 wins the first pick
            pkt_cnt_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= BUSY;
                        g_q     <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (pkt_done) begin
                        state_q   <= IDLE;
                        lp_q      <= g_q;
                        pkt_cnt_q <= pkt_cnt_q + 1'b1;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign pkt_cnt = pkt_cnt_q;

endmodule
